// File: rtl/traffic_light.sv
// traffic_light: two-street intersection controller.
//
// Street A and street B alternate right-of-way. Each green phase is timed by a
// two-digit BCD countdown. At expiry the phase changes only if the other street
// has a waiting vehicle; otherwise the current green is reloaded. A single
// priority request (A or B alone) forces the requested street green. If both
// requests are active, they are ignored.
//
// Parameters:
//   A_GREEN      BCD green time of street A in ticks (01..99)
//   B_GREEN      BCD green time of street B in ticks (01..99)
//   TICK_CYCLES  clock cycles per countdown tick (>= 1)
//   ALL_RED      BCD all-red clearance time (only with TRAFFIC_LIGHT_ALL_RED_EN)
//
// Ports:
//   Clk                  clock, rising edge
//   R                    asynchronous active-low reset
//   TA, TB               vehicle present on street A / B
//   A, B                 priority request for street A / B
//   A_Time_H, A_Time_L   street A display, BCD tens / units ([0] = MSB)
//   B_Time_H, B_Time_L   street B display, BCD tens / units ([0] = MSB)
//   A_light, B_light     1 = green, 0 = red
//
// Optional feature macro: TRAFFIC_LIGHT_ALL_RED_EN
//   When defined, every phase switch passes through an all-red clearance
//   phase. The clearance phase lasts ALL_RED ticks.

module traffic_light #(
    parameter logic [7:0]  A_GREEN     = 8'h20,
    parameter logic [7:0]  B_GREEN     = 8'h15,
`ifdef TRAFFIC_LIGHT_ALL_RED_EN
    parameter logic [7:0]  ALL_RED     = 8'h02,
`endif
    parameter int unsigned TICK_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       R,
    input  logic       TA,
    input  logic       TB,
    input  logic       A,
    input  logic       B,
    output logic [0:3] A_Time_L,
    output logic [0:3] A_Time_H,
    output logic [0:3] B_Time_L,
    output logic [0:3] B_Time_H,
    output logic       A_light,
    output logic       B_light
);

`ifdef TRAFFIC_LIGHT_ALL_RED_EN
    typedef enum logic [1:0] {PhA, PhB, PhClr} phase_e;
`else
    typedef enum logic [1:0] {PhA, PhB} phase_e;
`endif

    // Keep at least one prescaler bit so that TICK_CYCLES == 1 stays legal.
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TickLast = PW'(TICK_CYCLES - 1);

    phase_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          a_light_q, a_light_d;
    logic          b_light_q, b_light_d;
    logic          tick;
    logic          pri_a, pri_b;
    logic          count_last;
    logic          go_a, go_b;
`ifdef TRAFFIC_LIGHT_ALL_RED_EN
    phase_e        target_q, target_d;
`endif

    // BCD decrement. The caller guarantees that the input is never 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign tick       = (presc_q == TickLast);
    assign pri_a      = A & ~B;
    assign pri_b      = B & ~A;
    assign count_last = (count_q == 8'h01);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        go_a    = 1'b0;
        go_b    = 1'b0;
`ifdef TRAFFIC_LIGHT_ALL_RED_EN
        target_d = target_q;
`endif

        case (state_q)
            PhA: begin
                if (pri_b) begin
                    go_b    = 1'b1;
                    presc_d = '0;
                end else if (pri_a) begin
                    // Street A already has green, so hold the count.
                    count_d = count_q;
                end else if (tick) begin
                    if (count_last) begin
                        if (TB) begin
                            go_b = 1'b1;
                        end else begin
                            count_d = A_GREEN;
                        end
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
            PhB: begin
                if (pri_a) begin
                    go_a    = 1'b1;
                    presc_d = '0;
                end else if (pri_b) begin
                    count_d = count_q;
                end else if (tick) begin
                    if (count_last) begin
                        if (TA) begin
                            go_a = 1'b1;
                        end else begin
                            count_d = B_GREEN;
                        end
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
`ifdef TRAFFIC_LIGHT_ALL_RED_EN
            PhClr: begin
                // During clearance, priority only chooses the phase entered next.
                if (pri_a) begin
                    target_d = PhA;
                end else if (pri_b) begin
                    target_d = PhB;
                end
                if (tick) begin
                    if (count_last) begin
                        state_d = target_d;
                        count_d = (target_d == PhA) ? A_GREEN : B_GREEN;
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
`endif
            default: begin
                state_d = PhA;
                count_d = A_GREEN;
            end
        endcase

`ifdef TRAFFIC_LIGHT_ALL_RED_EN
        if (go_a) begin
            state_d  = PhClr;
            target_d = PhA;
            count_d  = ALL_RED;
        end else if (go_b) begin
            state_d  = PhClr;
            target_d = PhB;
            count_d  = ALL_RED;
        end
`else
        if (go_a) begin
            state_d = PhA;
            count_d = A_GREEN;
        end else if (go_b) begin
            state_d = PhB;
            count_d = B_GREEN;
        end
`endif

        // Lights follow the next state so that they change on the switching edge.
        a_light_d = (state_d == PhA);
        b_light_d = (state_d == PhB);
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q   <= PhA;
            count_q   <= A_GREEN;
            presc_q   <= '0;
            a_light_q <= 1'b1;
            b_light_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            a_light_q <= a_light_d;
            b_light_q <= b_light_d;
        end
    end

`ifdef TRAFFIC_LIGHT_ALL_RED_EN
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            target_q <= PhA;
        end else begin
            target_q <= target_d;
        end
    end
`endif

    // Both displays show the registered count directly.
    assign A_Time_H = count_q[7:4];
    assign A_Time_L = count_q[3:0];
    assign B_Time_H = count_q[7:4];
    assign B_Time_L = count_q[3:0];
    assign A_light  = a_light_q;
    assign B_light  = b_light_q;

    always_ff @(posedge Clk) begin
        assert (!(a_light_q && b_light_q));
    end

endmodule

// File: tb/tb_traffic_light.sv
module tb_traffic_light;

    logic       Clk = 1'b0;
    logic       R;
    logic       TA, TB, A, B;
    logic [0:3] A_Time_L, A_Time_H, B_Time_L, B_Time_H;
    logic       A_light, B_light;

    traffic_light dut (
        .Clk      (Clk),
        .R        (R),
        .TA       (TA),
        .TB       (TB),
        .A        (A),
        .B        (B),
        .A_Time_L (A_Time_L),
        .A_Time_H (A_Time_H),
        .B_Time_L (B_Time_L),
        .B_Time_H (B_Time_H),
        .A_light  (A_light),
        .B_light  (B_light)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit ta;
        bit tb;
        bit a;
        bit b;
        int cycles;
        bit exp_a_green;
        int exp_count;
    } vec_t;

    vec_t vecs[18];

    // Reference model: which street is green and the remaining count as a plain integer.
    bit m_a_green;
    int m_count;

    function automatic logic [17:0] observed();
        return {A_light, B_light, A_Time_H, A_Time_L, B_Time_H, B_Time_L};
    endfunction

    function automatic logic [17:0] expected(input bit a_green, input int cnt);
        logic [3:0] h;
        logic [3:0] l;
        h = 4'(cnt / 10);
        l = 4'(cnt % 10);
        return {a_green, ~a_green, h, l, h, l};
    endfunction

    task automatic check(input string name, input bit a_green, input int cnt);
        logic [17:0] got;
        logic [17:0] exp;
        got = observed();
        exp = expected(a_green, cnt);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got lights=%b%b time=%h%h/%h%h, required lights=%b%b time=%0d",
                     name, got[17], got[16], got[15:12], got[11:8], got[7:4], got[3:0],
                     a_green, ~a_green, cnt);
        end
    endtask

    task automatic model_step(input bit ta, input bit tb, input bit a, input bit b);
        bit pa;
        bit pb;
        pa = a && !b;
        pb = b && !a;
        if (m_a_green) begin
            if (pb) begin
                m_a_green = 1'b0;
                m_count   = 15;
            end else if (!pa) begin
                if (m_count == 1) begin
                    if (tb) begin
                        m_a_green = 1'b0;
                        m_count   = 15;
                    end else begin
                        m_count = 20;
                    end
                end else begin
                    m_count--;
                end
            end
        end else begin
            if (pa) begin
                m_a_green = 1'b1;
                m_count   = 20;
            end else if (!pb) begin
                if (m_count == 1) begin
                    if (ta) begin
                        m_a_green = 1'b1;
                        m_count   = 20;
                    end else begin
                        m_count = 15;
                    end
                end else begin
                    m_count--;
                end
            end
        end
    endtask

    // Apply inputs just after an edge. Then wait until shortly after the next edge.
    task automatic cycle(input bit ta, input bit tb, input bit a, input bit b);
        TA = ta;
        TB = tb;
        A  = a;
        B  = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        R  = 1'b0;
        TA = 1'b0;
        TB = 1'b0;
        A  = 1'b0;
        B  = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        R = 1'b1;
        m_a_green = 1'b1;
        m_count   = 20;
    endtask

    initial begin
        // ta tb a b cycles a_green count
        vecs[0]  = '{1, 1, 0, 0, 19, 1, 1};
        vecs[1]  = '{1, 1, 0, 0, 1,  0, 15};
        vecs[2]  = '{1, 1, 0, 0, 5,  0, 10};
        vecs[3]  = '{1, 1, 0, 0, 1,  0, 9};
        vecs[4]  = '{1, 1, 0, 0, 8,  0, 1};
        vecs[5]  = '{1, 1, 0, 0, 1,  1, 20};
        vecs[6]  = '{0, 0, 0, 0, 19, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 1,  1, 20};
        vecs[8]  = '{1, 1, 0, 0, 20, 0, 15};
        vecs[9]  = '{0, 1, 0, 0, 14, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 1,  0, 15};
        vecs[11] = '{1, 1, 0, 0, 3,  0, 12};
        vecs[12] = '{1, 1, 1, 0, 1,  1, 20};
        vecs[13] = '{1, 1, 1, 0, 5,  1, 20};
        vecs[14] = '{1, 1, 1, 1, 10, 1, 10};
        vecs[15] = '{1, 1, 0, 0, 1,  1, 9};
        vecs[16] = '{0, 0, 0, 1, 1,  0, 15};
        vecs[17] = '{0, 0, 0, 1, 3,  0, 15};

        do_reset();
        check("reset", 1'b1, 20);

        for (int i = 0; i < 18; i++) begin
            for (int k = 0; k < vecs[i].cycles; k++) begin
                cycle(vecs[i].ta, vecs[i].tb, vecs[i].a, vecs[i].b);
            end
            check($sformatf("vec%0d", i), vecs[i].exp_a_green, vecs[i].exp_count);
        end

        // Release priority B. The countdown resumes from the frozen value.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_release", 1'b0, 14);

        // Assert reset between clock edges. It must take effect without an edge.
        #2;
        R = 1'b0;
        #1;
        check("async_reset", 1'b1, 20);
        @(posedge Clk);
        #1;
        check("reset_hold", 1'b1, 20);
        R = 1'b1;
        m_a_green = 1'b1;
        m_count   = 20;

        // Randomized run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit ta;
            bit tb;
            bit a;
            bit b;
            ta = ($urandom_range(0, 3) != 0);
            tb = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 15) == 0);
            b  = ($urandom_range(0, 15) == 0);
            cycle(ta, tb, a, b);
            model_step(ta, tb, a, b);
            check($sformatf("rand%0d", n), m_a_green, m_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
